tcm_boot_ctrl: RTL
==================

# tcm_boot_ctrl

Boot sequencer for the RISC-V TCM SoC. It streams a program image into the TCM instruction write port and holds the core in reset while loading. It then releases the core, watches the fetch stage for the halt instruction, and reports completion or timeout with a cycle count. It replaces the ad-hoc load/reset/monitor sequencing of the bench and sits between an image source and the `riscv_tcm_top` tb_inst_* and rst_cpu_i ports.

## Interface
- LOAD_WORDS, 100: words written per boot (1..65535)
- BASE_ADDR, 32'h0: byte address of the first word
- HALT_INST, 32'h0000_8067: fetched instruction that signals program end
- CPU_RST_CYCLES, 1: cycles rst_cpu_o is pulsed after load (>=1)
- DRAIN_CYCLES, 5: cycles the core keeps running after halt is seen
- TIMEOUT_CYCLES, 40000: RUN cycle limit
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  asynchronous, active-low reset
- start_i  in  1  one-cycle boot request, honoured only in IDLE
- abort_i  in  1  return to IDLE from any state
- ld_valid_i  in  1  image word valid
- ld_data_i  in  32  image word
- ld_ready_o  out  1  word accepted when ld_valid_i && ld_ready_o
- inst_we_o  out  4  byte enables to tb_inst_we_i: 4'hf or 4'h0
- inst_addr_o  out  32  to tb_inst_addr_i
- inst_data_o  out  32  to tb_inst_data_i
- rst_cpu_o  out  1  to rst_cpu_i; active-high core reset
- fetch_inst_i  in  32  core fetch instruction (u_fetch.icache_inst_i)
- busy_o  out  1  state not IDLE/DONE/TIMEOUT
- done_o  out  1  level, state DONE
- timeout_o  out  1  level, state TIMEOUT
- cycle_count_o  out  32  RUN+DRAIN cycles of last boot, saturating at 32'hffff_ffff

## Operation
- FSM states: IDLE, LOAD, GAP, CPU_RST, RUN, DRAIN, DONE, TIMEOUT.
- IDLE: start_i moves to LOAD. On entry to LOAD, word index and cycle_count_o clear.
- LOAD: ld_ready_o=1. Each handshake registers inst_we_o=4'hf, inst_addr_o=BASE_ADDR+4*idx and inst_data_o=ld_data_i for exactly one cycle, then increments idx. With no handshake, inst_we_o=0. After the LOAD_WORDS-th handshake, the state moves to GAP and ld_ready_o drops in the same edge.
- GAP: lasts one cycle and lets the final write retire. It then moves to CPU_RST.
- CPU_RST: lasts CPU_RST_CYCLES cycles, then moves to RUN.
- rst_cpu_o=1 in IDLE, LOAD, GAP, CPU_RST, DONE and TIMEOUT. It is 0 only in RUN and DRAIN.
- RUN: cycle_count_o increments every cycle.
  - If fetch_inst_i==HALT_INST, move to DRAIN.
  - Else, if count reaches TIMEOUT_CYCLES, move to TIMEOUT.
  - If halt and timeout occur in the same cycle, halt wins.
- DRAIN: the counter keeps incrementing. After DRAIN_CYCLES cycles, move to DONE.
- DONE and TIMEOUT: hold their state. start_i begins a new boot by going to LOAD, which clears done_o/timeout_o.
- abort_i takes priority over every other condition. The next state is IDLE, with inst_we_o=0 and rst_cpu_o=1 from the next cycle. cycle_count_o is kept.
- inst_addr_o wraps modulo 2^32.
- ld_data_i is ignored outside LOAD. fetch_inst_i is ignored outside RUN.

## Timing
- Reset values:
  - state IDLE, idx 0
  - ld_ready_o 0, inst_we_o 4'h0, inst_addr_o 0, inst_data_o 0
  - rst_cpu_o 1
  - busy_o 0, done_o 0, timeout_o 0, cycle_count_o 0
- All outputs are registered. start_i sampled at edge T gives LOAD and ld_ready_o=1 from T+1.
- A handshake at edge N drives the write on the port during cycle N+1.
- With ld_valid_i held high, the load takes LOAD_WORDS cycles. rst_cpu_o falls 1+CPU_RST_CYCLES cycles after the last write cycle.
- Halt seen at edge H gives done_o=1 at H+DRAIN_CYCLES+1. rst_cpu_o rises in the same cycle.
- Asserting reset mid-operation forces all reset values immediately, including rst_cpu_o=1 and inst_we_o=0.

## Test plan
- Streamed load: LOAD_WORDS=4, words A0..A3 presented back-to-back -> four consecutive writes with we=4'hf at addr 0,4,8,12 carrying A0..A3. rst_cpu_o falls 2 cycles after the write at addr 12.
- Gapped stream: ld_valid_i toggled every other cycle -> writes occur only after handshakes. Addresses are contiguous and inst_we_o=0 between writes.
- Halt: fetch_inst_i=32'h0000_8067 in the 10th RUN cycle -> done_o=1 and rst_cpu_o=1 six cycles later, cycle_count_o=15.
- Timeout: TIMEOUT_CYCLES=50 and no halt -> timeout_o=1, rst_cpu_o=1, cycle_count_o=50. Halt in the same cycle as the limit -> DRAIN, not TIMEOUT.
- Abort/reset: abort_i during LOAD after 2 words -> IDLE, ld_ready_o=0, no further writes. A following start_i restarts at BASE_ADDR. Reset asserted in RUN -> all outputs at reset values asynchronously.
- Reboot: start_i in DONE -> done_o clears, cycle_count_o=0, full load repeats.

Source files
------------

// File: rtl/tcm_boot_ctrl_if.sv
// Bundle between the boot controller, the image source and the TCM SoC.
// The master side is the controller and the slave side is the SoC plus the loader.
interface tcm_boot_ctrl_if;
  logic        ld_valid_i;
  logic [31:0] ld_data_i;
  logic        ld_ready_o;
  logic [3:0]  inst_we_o;
  logic [31:0] inst_addr_o;
  logic [31:0] inst_data_o;
  logic        rst_cpu_o;
  logic [31:0] fetch_inst_i;

  modport master (
    input  ld_valid_i, ld_data_i, fetch_inst_i,
    output ld_ready_o, inst_we_o, inst_addr_o, inst_data_o, rst_cpu_o
  );

  modport slave (
    output ld_valid_i, ld_data_i, fetch_inst_i,
    input  ld_ready_o, inst_we_o, inst_addr_o, inst_data_o, rst_cpu_o
  );
endinterface

// File: rtl/tcm_boot_ctrl.sv
// Boot sequencer: streams an image into the TCM, pulses the core reset, then
// runs the core until the halt instruction is fetched or the cycle limit expires.
module tcm_boot_ctrl #(
  parameter int          LOAD_WORDS     = 100,
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter logic [31:0] HALT_INST      = 32'h0000_8067,
  parameter int          CPU_RST_CYCLES = 1,
  parameter int          DRAIN_CYCLES   = 5,
  parameter int          TIMEOUT_CYCLES = 40000
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   abort_i,
  tcm_boot_ctrl_if.master        bus,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   timeout_o,
  output logic [31:0]            cycle_count_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_GAP, S_CPU_RST, S_RUN, S_DRAIN, S_DONE, S_TIMEOUT
  } state_e;

  localparam logic [15:0] LAST_IDX     = 16'(LOAD_WORDS - 1);
  localparam logic [31:0] CPU_RST_LAST = 32'(CPU_RST_CYCLES - 1);
  localparam logic [31:0] DRAIN_LAST   = 32'(DRAIN_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LIM  = 32'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic [31:0] sub_q, sub_d;
  logic [31:0] count_q, count_d;
  logic        ld_ready_q, ld_ready_d;
  logic [3:0]  we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        rst_cpu_q, rst_cpu_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        timeout_q, timeout_d;
  logic        handshake;
  logic [31:0] count_inc;

  assign handshake = bus.ld_valid_i && ld_ready_q;
  assign count_inc = (count_q == 32'hffff_ffff) ? count_q : count_q + 32'd1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sub_d   = sub_q;
    count_d = count_q;
    we_d    = 4'h0;
    addr_d  = addr_q;
    data_d  = data_q;

    if (abort_i) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE, S_TIMEOUT: begin
          if (start_i) begin
            state_d = S_LOAD;
            idx_d   = 16'd0;
            count_d = 32'd0;
          end
        end
        S_LOAD: begin
          if (handshake) begin
            we_d   = 4'hf;
            addr_d = BASE_ADDR + {14'd0, idx_q, 2'b00};
            data_d = bus.ld_data_i;
            if (idx_q == LAST_IDX) begin
              state_d = S_GAP;
            end else begin
              idx_d = idx_q + 16'd1;
            end
          end
        end
        S_GAP: begin
          state_d = S_CPU_RST;
          sub_d   = 32'd0;
        end
        S_CPU_RST: begin
          if (sub_q == CPU_RST_LAST) begin
            state_d = S_RUN;
          end else begin
            sub_d = sub_q + 32'd1;
          end
        end
        S_RUN: begin
          count_d = count_inc;
          // Halt is checked first so it wins over a timeout landing in the same cycle.
          if (bus.fetch_inst_i == HALT_INST) begin
            sub_d   = 32'd0;
            state_d = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
          end else if (count_inc >= TIMEOUT_LIM) begin
            state_d = S_TIMEOUT;
          end
        end
        S_DRAIN: begin
          count_d = count_inc;
          if (sub_q == DRAIN_LAST) begin
            state_d = S_DONE;
          end else begin
            sub_d = sub_q + 32'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    ld_ready_d = (state_d == S_LOAD);
    rst_cpu_d  = !((state_d == S_RUN) || (state_d == S_DRAIN));
    busy_d     = !((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_TIMEOUT));
    done_d     = (state_d == S_DONE);
    timeout_d  = (state_d == S_TIMEOUT);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      idx_q      <= 16'd0;
      sub_q      <= 32'd0;
      count_q    <= 32'd0;
      ld_ready_q <= 1'b0;
      we_q       <= 4'h0;
      addr_q     <= 32'd0;
      data_q     <= 32'd0;
      rst_cpu_q  <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      sub_q      <= sub_d;
      count_q    <= count_d;
      ld_ready_q <= ld_ready_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      rst_cpu_q  <= rst_cpu_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
    end
  end

  assign bus.ld_ready_o  = ld_ready_q;
  assign bus.inst_we_o   = we_q;
  assign bus.inst_addr_o = addr_q;
  assign bus.inst_data_o = data_q;
  assign bus.rst_cpu_o   = rst_cpu_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign timeout_o       = timeout_q;
  assign cycle_count_o   = count_q;

endmodule
